// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: one shift-add or restoring
// shift-subtract step per cycle, W cycles per MULT/DIV, with MTHI/MTLO writes.
module mul_div_unit #(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] rs_data,
    input  logic [W-1:0] rt_data,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    localparam logic [2:0]       OP_MTHI  = 3'b100;
    localparam logic [2:0]       OP_MTLO  = 3'b101;
    localparam logic [W-1:0]     ONE_W    = 1;
    localparam logic [2*W-1:0]   ONE_2W   = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(W);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             divz_q, divz_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic [2*W-1:0]   work_q, work_d;

    function automatic logic [W-1:0] abs_val(input logic [W-1:0] v, input logic sgn);
        return (sgn && v[W-1]) ? (~v + ONE_W) : v;
    endfunction

    function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
        return neg ? (~v + ONE_W) : v;
    endfunction

    function automatic logic [2*W-1:0] cond_neg2(input logic [2*W-1:0] v, input logic neg);
        return neg ? (~v + ONE_2W) : v;
    endfunction

    logic           sgn_op;
    logic [W-1:0]   abs_rs, abs_rt;
    logic [W:0]     mac_sum;
    logic [W:0]     rem_sh;
    logic [W-1:0]   div_diff;
    logic           div_ge;
    logic [W-1:0]   rem_next;
    logic [2*W-1:0] mul_res;
    logic [W-1:0]   quo_res, rem_res;

    // Work register: multiply keeps {partial, multiplier}; divide keeps {remainder, quotient}.
    always_comb begin
        sgn_op   = ~op[0];
        abs_rs   = abs_val(rs_data, sgn_op);
        abs_rt   = abs_val(rt_data, sgn_op);
        mac_sum  = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = work_q[2*W-1:W-1];
        div_ge   = rem_sh >= {1'b0, opnd_q};
        div_diff = rem_sh[W-1:0] - opnd_q;
        rem_next = div_ge ? div_diff : rem_sh[W-1:0];
        mul_res  = cond_neg2(work_q, neg_lo_q);
        quo_res  = divz_q ? '1 : cond_neg(work_q[W-1:0], neg_lo_q);
        rem_res  = cond_neg(work_q[2*W-1:W], neg_hi_q);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = (state_q == CALC);
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        divz_d   = divz_q;
        opnd_d   = opnd_q;
        work_d   = work_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        is_div_d = op[1];
                        neg_lo_d = sgn_op & (rs_data[W-1] ^ rt_data[W-1]);
                        neg_hi_d = sgn_op & rs_data[W-1];
                        divz_d   = op[1] & (rt_data == '0);
                        opnd_d   = op[1] ? abs_rt : abs_rs;
                        work_d   = {{W{1'b0}}, (op[1] ? abs_rs : abs_rt)};
                        cnt_d    = CNT_INIT;
                        state_d  = CALC;
                    end else if (op == OP_MTHI) begin
                        hi_d = rs_data;
                    end else if (op == OP_MTLO) begin
                        lo_d = rs_data;
                    end
                end
            end
            CALC: begin
                work_d = is_div_q ? {rem_next, work_q[W-2:0], div_ge}
                                  : {mac_sum, work_q[W-1:1]};
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                cnt_d   = '0;
                if (is_div_q) begin
                    hi_d = rem_res;
                    lo_d = quo_res;
                end else begin
                    {hi_d, lo_d} = mul_res;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            divz_q   <= divz_d;
        end
    end

    // Operand/work datapath needs no reset: it is always loaded before it is consumed.
    always_ff @(posedge clk) begin
        opnd_q <= opnd_d;
        work_q <= work_d;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: a 64-bit arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed HI/LO values.
module tb_mul_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.W(W), .CNT_W(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    // Reference arithmetic: returns {hi, lo} for a MULT/DIV op.
    function automatic logic [2*W-1:0] model_result(input logic [2:0] o,
                                                    input logic [W-1:0] a,
                                                    input logic [W-1:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [2*W-1:0]  r;
        sa = 64'($signed(a));
        sb = 64'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        r  = '0;
        case (o)
            3'd0: r = 64'(sa * sb);
            3'd1: r = 64'(ua * ub);
            3'd2: if (b == '0) r = {a, {W{1'b1}}};
                  else r = {W'(sa % sb), W'(sa / sb)};
            3'd3: if (b == '0) r = {a, {W{1'b1}}};
                  else r = {W'(ua % ub), W'(ua / ub)};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Timing model: accepted at edge 0, busy after edges 1..W, result and done after edge W+1.
    bit           model_ok = 1'b0;
    bit           m_act    = 1'b0;
    int           m_age    = 0;
    logic         m_busy   = 1'b0;
    logic         m_done   = 1'b0;
    logic [W-1:0] m_hi     = '0;
    logic [W-1:0] m_lo     = '0;
    logic [W-1:0] r_hi     = '0;
    logic [W-1:0] r_lo     = '0;

    always @(posedge clk) begin
        if (reset) begin
            model_ok = 1'b1;
            m_act    = 1'b0;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_hi     = '0;
            m_lo     = '0;
        end else begin
            m_done = 1'b0;
            if (m_act) begin
                m_age++;
                m_busy = (m_age <= W);
                if (m_age == W + 1) begin
                    m_act  = 1'b0;
                    m_done = 1'b1;
                    m_hi   = r_hi;
                    m_lo   = r_lo;
                end
            end else begin
                m_busy = 1'b0;
                if (start) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            m_act = 1'b1;
                            m_age = 0;
                            {r_hi, r_lo} = model_result(op, rs_data, rt_data);
                        end
                        3'd4: m_hi = rs_data;
                        3'd5: m_lo = rs_data;
                        default: ;
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if ({busy, done, hi, lo} !== {m_busy, m_done, m_hi, m_lo}) begin
                failures++;
                $display("FAIL cycle_model t=%0t got busy=%b done=%b hi=%h lo=%h exp busy=%b done=%b hi=%h lo=%h",
                         $time, busy, done, hi, lo, m_busy, m_done, m_hi, m_lo);
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Called at a falling edge; start is sampled on the following rising edge.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(output int n, output int nbusy);
        n     = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
        end while (!done && n < 100);
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL wait_done timeout cycles=%0d", n);
        end
    endtask

    task automatic run(input string name, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                       input logic [W-1:0] exp_lo);
        int n, nb;
        do_op(o, a, b);
        wait_done(n, nb);
        chk({name, "_hi"}, hi, exp_hi);
        chk({name, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int n, nb, dcnt;
        reset   = 1'b1;
        start   = 1'b0;
        op      = 3'd0;
        rs_data = '0;
        rt_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(n, nb);
        chk("multu_latency", 32'(n), 32'd33);
        chk("multu_busy_cycles", 32'(nb), 32'd32);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        run("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("divu_zero", 3'd3, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
        run("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run("div_zero_neg", 3'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
        run("mult_min", 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run("divu_big", 3'd3, 32'hFFFFFFFF, 32'd3, 32'h00000000, 32'h55555555);
        run("div_negdvs", 3'd2, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);

        do_op(3'd4, 32'hDEADBEEF, 32'h0);
        chk("mthi_hi", hi, 32'hDEADBEEF);
        chk("mthi_busy", 32'(busy), 32'd0);
        do_op(3'd5, 32'h0BADF00D, 32'h0);
        chk("mtlo_lo", lo, 32'h0BADF00D);
        do_op(3'd6, 32'h11111111, 32'h2);
        do_op(3'd7, 32'h22222222, 32'h3);
        @(negedge clk);
        chk("nop_hi", hi, 32'hDEADBEEF);
        chk("nop_lo", lo, 32'h0BADF00D);
        chk("nop_busy", 32'(busy), 32'd0);

        do_op(3'd2, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        do_op(3'd5, 32'h000000A5, 32'h0);
        wait_done(n, nb);
        chk("mtlo_busy_lo", lo, 32'h0000000E);
        chk("mtlo_busy_hi", hi, 32'h00000002);

        do_op(3'd0, 32'h00012345, 32'd678);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
